// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, address and full/almost-full/level/overflow flags of an async FIFO
// Ports:
//   clk_in, reset_in   write-domain clock, synchronous active-high reset
//   wr_req_in          producer write request
//   rptr_sync_in       Gray read pointer already synchronized into this domain
//   wr_en_out          memory write enable (combinational)
//   waddr_out          memory write address (binary pointer low bits)
//   wptr_out           Gray write pointer for the read-domain synchronizer
//   full_out, afull_out, level_out, overflow_out   registered status
module fifo_wptr_full #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  wr_req_in,
    input  logic [ADDR_WIDTH:0]   rptr_sync_in,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] waddr_out,
    output logic [ADDR_WIDTH:0]   wptr_out,
    output logic                  full_out,
    output logic                  afull_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  overflow_out
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [PW-1:0] wbin, wbin_next, wgray_next, rbin, level_next;
    logic          full_next;
    assign wr_en_out = wr_req_in & ~full_out & ~reset_in;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) rbin[i] = ^(rptr_sync_in >> i);
    end
    always_comb begin
        wbin_next  = wbin + PW'(wr_en_out);
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        // full when the write pointer is exactly one lap ahead of the read pointer
        full_next  = wgray_next == {~rptr_sync_in[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync_in[ADDR_WIDTH-2:0]};
        level_next = wbin_next - rbin;
    end
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wbin         <= '0;
            wptr_out     <= '0;
            waddr_out    <= '0;
            full_out     <= 1'b0;
            afull_out    <= 1'b0;
            level_out    <= '0;
            overflow_out <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr_out     <= wgray_next;
            waddr_out    <= wbin_next[ADDR_WIDTH-1:0];
            full_out     <= full_next;
            afull_out    <= level_next >= PW'(AFULL_LEVEL);
            level_out    <= level_next;
            overflow_out <= overflow_out | (wr_req_in & full_out);
        end
    end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed self-checking bench for fifo_wptr_full
module tb_fifo_wptr_full;
    logic       clk_in = 1'b0;
    logic       reset_in, wr_req_in;
    logic [4:0] rptr_sync_in;
    logic       wr_en_out, full_out, afull_out, overflow_out;
    logic [3:0] waddr_out;
    logic [4:0] wptr_out, level_out, prev;
    logic [4:0] wb;
    int n_tests = 0;
    int n_fail  = 0;

    fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_LEVEL(14)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .wr_req_in(wr_req_in),
        .rptr_sync_in(rptr_sync_in), .wr_en_out(wr_en_out), .waddr_out(waddr_out),
        .wptr_out(wptr_out), .full_out(full_out), .afull_out(afull_out),
        .level_out(level_out), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wptr"}, wptr_out, 0);
        chk({tag, "_waddr"}, waddr_out, 0);
        chk({tag, "_full"}, full_out, 0);
        chk({tag, "_afull"}, afull_out, 0);
        chk({tag, "_level"}, level_out, 0);
        chk({tag, "_ovf"}, overflow_out, 0);
    endtask

    initial begin
        reset_in = 1'b1; wr_req_in = 1'b1; rptr_sync_in = 5'b00000;
        repeat (3) step();
        chk_zero("rst");
        chk("rst_wren", wr_en_out, 0);
        reset_in = 1'b0;
        #1;
        chk("fill_wren", wr_en_out, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("fill_wptr", wptr_out, g(5'(i)));
            chk("fill_waddr", waddr_out, i % 16);
            chk("fill_level", level_out, i);
            chk("fill_afull", afull_out, i >= 14);
            chk("fill_full", full_out, i == 16);
            if (i == 1) chk("fill_g1", wptr_out, 5'b00001);
            if (i == 2) chk("fill_g2", wptr_out, 5'b00011);
            if (i == 3) chk("fill_g3", wptr_out, 5'b00010);
            if (i == 4) chk("fill_g4", wptr_out, 5'b00110);
        end
        chk("full_wptr", wptr_out, 5'b11000);
        chk("full_ovf0", overflow_out, 0);
        chk("ovf_wren", wr_en_out, 0);
        step();
        chk("ovf_wptr", wptr_out, 5'b11000);
        chk("ovf_set", overflow_out, 1);
        chk("ovf_level", level_out, 16);
        wr_req_in = 1'b0;
        step();
        chk("ovf_sticky", overflow_out, 1);
        chk("ovf_wptr2", wptr_out, 5'b11000);
        chk("ovf_full", full_out, 1);
        rptr_sync_in = 5'b00001;
        step();
        chk("drain_full", full_out, 0);
        chk("drain_level", level_out, 15);
        chk("drain_afull", afull_out, 1);
        wr_req_in = 1'b1;
        #1;
        chk("refill_wren", wr_en_out, 1);
        step();
        chk("refill_wptr", wptr_out, 5'b11001);
        chk("refill_full", full_out, 1);
        chk("refill_level", level_out, 16);
        wr_req_in = 1'b0;
        rptr_sync_in = g(5'd8);
        step();
        chk("mid_level", level_out, 9);
        chk("mid_full", full_out, 0);
        chk("mid_ovf", overflow_out, 1);
        reset_in = 1'b1; wr_req_in = 1'b1; rptr_sync_in = 5'b00000;
        #1;
        chk("mid_rst_wren", wr_en_out, 0);
        step();
        chk_zero("mid_rst");
        reset_in = 1'b0;
        step();
        chk("resume_wptr", wptr_out, 5'b00001);
        chk("resume_level", level_out, 1);
        wb = 5'd1;
        for (int i = 0; i < 40; i++) begin
            rptr_sync_in = g(wb - 5'd2);
            prev = wptr_out;
            wb = wb + 5'd1;
            step();
            chk("wrap_wptr", wptr_out, g(wb));
            chk("wrap_waddr", waddr_out, wb[3:0]);
            chk("wrap_level", level_out, 3);
            chk("wrap_full", full_out, 0);
            chk("wrap_afull", afull_out, 0);
            chk("wrap_gray1", $countones(prev ^ wptr_out), 1);
            if (wb == 5'd0) begin
                chk("wrap_prev", prev, 5'b10000);
                chk("wrap_zero", wptr_out, 5'b00000);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and flag generator for the asynchronous FIFO, running entirely in the write clock domain.
- Gates write requests into memory write enables and produces the binary memory address.
- Publishes a registered Gray-coded write pointer for the two-flop pointer synchronizer that carries it into the read domain.
- Consumes the read pointer already synchronized into the write domain and derives full, almost-full, fill level and a sticky overflow error.

Parameters:
ADDR_WIDTH, 4, memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2
AFULL_LEVEL, 14, fill level at or above which afull_out asserts; legal range 1..2**ADDR_WIDTH

Ports:
clk_in  input  1  write-domain clock; all logic on rising edge
reset_in  input  1  synchronous, active-high reset
wr_req_in  input  1  write request from producer, sampled each clk_in edge
rptr_sync_in  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into this domain
wr_en_out  output  1  memory write enable (combinational)
waddr_out  output  ADDR_WIDTH  memory write address = low bits of binary write pointer (registered)
wptr_out  output  ADDR_WIDTH+1  Gray write pointer to the cross-domain synchronizer (registered)
full_out  output  1  FIFO full (registered)
afull_out  output  1  level >= AFULL_LEVEL (registered)
level_out  output  ADDR_WIDTH+1  write-side fill level, 0..2**ADDR_WIDTH (registered)
overflow_out  output  1  sticky: write requested while full (registered)

Behaviour:
- Clock and reset: single clock clk_in. reset_in is synchronous and active-high; it is sampled only on the clk_in rising edge.
- Reset values: on any edge with reset_in=1, the binary pointer wbin, wptr_out, waddr_out, full_out, afull_out, level_out and overflow_out all become 0. Reset has priority over every other event.
- Write gating: wr_en_out = wr_req_in & ~full_out & ~reset_in. This is the only combinational output.
- Next-pointer arithmetic:
  - wbin_next = wbin + wr_en_out, modulo 2**(ADDR_WIDTH+1); wraps naturally.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Register updates each edge: wbin <= wbin_next; wptr_out <= wgray_next; waddr_out <= wbin_next[ADDR_WIDTH-1:0].
- Latency: a write accepted at edge N updates wptr_out and waddr_out at edge N. Memory is written at address waddr_out (pre-edge value) when wr_en_out=1.
- Gray invariant: wptr_out changes by at most one bit per clock. This is mandatory for the cross-domain transfer.
- Full flag:
  - full_next = (wgray_next == {~rptr_sync_in[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync_in[ADDR_WIDTH-2:0]}).
  - full_out <= full_next, so full asserts on the same edge as the filling write, with no bubble.
- Read-pointer decode: rbin is the Gray-to-binary decode of rptr_sync_in, combinational: rbin[MSB] = g[MSB]; rbin[i] = rbin[i+1] ^ g[i].
- Fill level: level_next = wbin_next - rbin, modulo 2**(ADDR_WIDTH+1). level_out <= level_next. afull_out <= (level_next >= AFULL_LEVEL).
- Conservatism: level and flags are pessimistic because the read pointer arrives at least two write clocks late. Full may persist for up to 2-3 cycles after a read; it never deasserts early.
- Overflow: overflow_out <= overflow_out | (wr_req_in & full_out). It is cleared only by reset. A rejected write changes no pointer.
- Simultaneous write and read-pointer advance: both are applied in the same next-state computation. The level stays unchanged, and full remains set only if the compare still matches.
- Reset mid-operation: the pointer is forced to 0 on the reset edge regardless of wr_req_in. The read side must be reset concurrently; this block does not check that.
- rptr_sync_in is trusted. There is no range checking of illegal Gray codes.

Test Plan:
1. Reset: reset_in=1 for 3 edges with wr_req_in=1 -> all outputs 0, wr_en_out=0, wptr_out=5'b00000.
2. Fill (ADDR_WIDTH=4, rptr_sync_in=0): 16 back-to-back requests.
   - wptr_out steps 00001, 00011, 00010, 00110, ...
   - afull_out=1 at the edge where level becomes 14.
   - After the 16th edge: full_out=1, level_out=16, wptr_out=5'b11000.
3. Overflow: request a 17th write while full -> wr_en_out=0, wptr_out stays 11000, overflow_out=1 and remains 1 after wr_req_in drops.
4. Drain visibility: from full, set rptr_sync_in=5'b00001 -> next edge full_out=0, level_out=15. A write in that cycle re-asserts full with wptr_out=5'b11001.
5. Wrap: 40 writes, with rptr_sync_in tracking the write pointer 3 writes behind.
   - At binary 31 -> 32 (0), wptr_out goes 10000 -> 00000.
   - full_out stays 0, level_out=3 steady.
   - A checker confirms one-bit Gray changes on every step.
6. Mid-operation reset: assert reset_in at level 9 -> the next edge zeroes all outputs, including a previously set overflow_out. Writes resume from wptr_out=0.
